// File: rtl/ddr_gearbox_ser.sv
// N:1 output serializer: a RATIO-slice parallel word enters through valid/ready,
// is double-buffered (hold + shift register) and leaves one W-bit slice per clock.
module ddr_gearbox_ser #(
    parameter int unsigned     W         = 1,
    parameter int unsigned     RATIO     = 2,
    parameter int unsigned     MSB_FIRST = 0,
    parameter logic [W-1:0]    INIT      = '0,
    parameter int unsigned     IDLE_MODE = 0
) (
    input  logic                 C,
    input  logic                 CLR_N,
    input  logic                 CE,
    input  logic                 R,
    input  logic                 S,
    input  logic [W*RATIO-1:0]   D,
    input  logic                 D_VALID,
    output logic                 D_READY,
    output logic [W-1:0]         Q,
    output logic                 Q_VALID,
    output logic                 UNDERRUN
);

    localparam int unsigned DW = W * RATIO;
    localparam int unsigned IW = $clog2(RATIO);

    logic [DW-1:0] hold;
    logic          hold_full;
    logic [DW-1:0] sr;
    logic [IW-1:0] idx;
    logic [IW-1:0] rem;
    logic          accept;

    // Slice k of a word; MSB_FIRST mirrors the order at slice granularity only.
    function automatic logic [W-1:0] slice_of(input logic [DW-1:0] word,
                                              input logic [IW-1:0] k);
        slice_of = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (k == IW'(i)) begin
                slice_of = word[W*((MSB_FIRST != 0) ? (RATIO-1-i) : i) +: W];
            end
        end
    endfunction

    assign D_READY = !hold_full && CE && !R && !S;
    assign accept  = D_VALID && D_READY;

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            hold      <= '0;
            hold_full <= 1'b0;
            sr        <= '0;
            idx       <= '0;
            rem       <= '0;
            Q         <= INIT;
            Q_VALID   <= 1'b0;
            UNDERRUN  <= 1'b0;
        end else if (CE) begin
            if (R) begin
                hold_full <= 1'b0;
                idx       <= '0;
                rem       <= '0;
                Q         <= '0;
                Q_VALID   <= 1'b0;
                UNDERRUN  <= 1'b0;
            end else if (S) begin
                Q         <= '1;
                Q_VALID   <= 1'b0;
                UNDERRUN  <= 1'b0;
            end else begin
                UNDERRUN <= 1'b0;
                if (rem != '0) begin
                    Q       <= slice_of(sr, idx);
                    idx     <= idx + IW'(1);
                    rem     <= rem - IW'(1);
                    Q_VALID <= 1'b1;
                end else if (hold_full) begin
                    Q         <= slice_of(hold, '0);
                    sr        <= hold;
                    idx       <= IW'(1);
                    rem       <= IW'(RATIO - 1);
                    hold_full <= 1'b0;
                    Q_VALID   <= 1'b1;
                end else begin
                    if (IDLE_MODE == 0) begin
                        Q <= INIT;
                    end
                    Q_VALID  <= 1'b0;
                    UNDERRUN <= Q_VALID;
                end
                // Accept never coincides with the load above: loading needs hold_full.
                if (accept) begin
                    hold      <= D;
                    hold_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_gearbox_ser.sv
// Directed bench for ddr_gearbox_ser: four W=2/RATIO=4 instances sharing one
// stimulus stream (LSB-first, MSB-first, INIT=2, IDLE_MODE=1 with INIT=1).
module tb_ddr_gearbox_ser;

    logic       C;
    logic       CLR_N;
    logic       CE;
    logic       R;
    logic       S;
    logic [7:0] D;
    logic       D_VALID;
    logic [3:0] rdy;
    logic [7:0] q4;
    logic [3:0] qv;
    logic [3:0] ur;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       ce;
        logic       r;
        logic       s;
        logic       dv;
        logic [7:0] d;
        logic       rdy;
        logic [7:0] q;
        logic       v;
        logic       u;
    } row_t;

    ddr_gearbox_ser #(.W(2), .RATIO(4), .MSB_FIRST(0), .INIT(2'b00), .IDLE_MODE(0)) u_a (
        .C(C), .CLR_N(CLR_N), .CE(CE), .R(R), .S(S), .D(D), .D_VALID(D_VALID),
        .D_READY(rdy[0]), .Q(q4[1:0]), .Q_VALID(qv[0]), .UNDERRUN(ur[0]));
    ddr_gearbox_ser #(.W(2), .RATIO(4), .MSB_FIRST(1), .INIT(2'b00), .IDLE_MODE(0)) u_b (
        .C(C), .CLR_N(CLR_N), .CE(CE), .R(R), .S(S), .D(D), .D_VALID(D_VALID),
        .D_READY(rdy[1]), .Q(q4[3:2]), .Q_VALID(qv[1]), .UNDERRUN(ur[1]));
    ddr_gearbox_ser #(.W(2), .RATIO(4), .MSB_FIRST(0), .INIT(2'b10), .IDLE_MODE(0)) u_c (
        .C(C), .CLR_N(CLR_N), .CE(CE), .R(R), .S(S), .D(D), .D_VALID(D_VALID),
        .D_READY(rdy[2]), .Q(q4[5:4]), .Q_VALID(qv[2]), .UNDERRUN(ur[2]));
    ddr_gearbox_ser #(.W(2), .RATIO(4), .MSB_FIRST(0), .INIT(2'b01), .IDLE_MODE(1)) u_d (
        .C(C), .CLR_N(CLR_N), .CE(CE), .R(R), .S(S), .D(D), .D_VALID(D_VALID),
        .D_READY(rdy[3]), .Q(q4[7:6]), .Q_VALID(qv[3]), .UNDERRUN(ur[3]));

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // q field packs expected Q as {u_d, u_c, u_b, u_a}.
    function automatic row_t mk(input logic ce, input logic r, input logic s,
                                input logic dv, input logic [7:0] d, input logic rdy_e,
                                input logic [7:0] q, input logic v, input logic u);
        row_t t;
        t.ce = ce; t.r = r; t.s = s; t.dv = dv; t.d = d;
        t.rdy = rdy_e; t.q = q; t.v = v; t.u = u;
        return t;
    endfunction

    task automatic test_reset();
        CLR_N = 1'b0; CE = 1'b1; R = 1'b0; S = 1'b0; D = 8'h00; D_VALID = 1'b0;
        repeat (2) @(posedge C);
        #1;
        checks++;
        if (q4 !== 8'h60) begin errors++; $display("FAIL reset Q got %h want %h", q4, 8'h60); end
        checks++;
        if (qv !== 4'h0) begin errors++; $display("FAIL reset Q_VALID got %b want %b", qv, 4'h0); end
        checks++;
        if (ur !== 4'h0) begin errors++; $display("FAIL reset UNDERRUN got %b want %b", ur, 4'h0); end
        checks++;
        if (rdy !== 4'hF) begin errors++; $display("FAIL reset D_READY got %b want %b", rdy, 4'hF); end
        CLR_N = 1'b1;
    endtask

    task automatic test_single_word();
        row_t rows[$];
        rows.push_back(mk(1,0,0,1,8'hE4, 1, 8'h60, 0,0));
        rows.push_back(mk(1,0,0,0,8'h00, 0, 8'h0C, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'h59, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hA6, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hF3, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hE0, 0,1));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hE0, 0,0));
        foreach (rows[i]) begin
            CE = rows[i].ce; R = rows[i].r; S = rows[i].s; D_VALID = rows[i].dv; D = rows[i].d;
            #1;
            checks++;
            if (rdy !== {4{rows[i].rdy}}) begin errors++; $display("FAIL single_word[%0d] D_READY got %b want %b", i, rdy, {4{rows[i].rdy}}); end
            @(posedge C); #1;
            checks++;
            if (q4 !== rows[i].q) begin errors++; $display("FAIL single_word[%0d] Q got %h want %h", i, q4, rows[i].q); end
            checks++;
            if (qv !== {4{rows[i].v}}) begin errors++; $display("FAIL single_word[%0d] Q_VALID got %b want %b", i, qv, {4{rows[i].v}}); end
            checks++;
            if (ur !== {4{rows[i].u}}) begin errors++; $display("FAIL single_word[%0d] UNDERRUN got %b want %b", i, ur, {4{rows[i].u}}); end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        rows.push_back(mk(1,0,0,1,8'hE4, 1, 8'hE0, 0,0));
        rows.push_back(mk(1,0,0,1,8'h1B, 0, 8'h0C, 1,0));
        rows.push_back(mk(1,0,0,1,8'h1B, 1, 8'h59, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 0, 8'hA6, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 0, 8'hF3, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 0, 8'hF3, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hA6, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'h59, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'h0C, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'h20, 0,1));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'h20, 0,0));
        foreach (rows[i]) begin
            CE = rows[i].ce; R = rows[i].r; S = rows[i].s; D_VALID = rows[i].dv; D = rows[i].d;
            #1;
            checks++;
            if (rdy !== {4{rows[i].rdy}}) begin errors++; $display("FAIL back_to_back[%0d] D_READY got %b want %b", i, rdy, {4{rows[i].rdy}}); end
            @(posedge C); #1;
            checks++;
            if (q4 !== rows[i].q) begin errors++; $display("FAIL back_to_back[%0d] Q got %h want %h", i, q4, rows[i].q); end
            checks++;
            if (qv !== {4{rows[i].v}}) begin errors++; $display("FAIL back_to_back[%0d] Q_VALID got %b want %b", i, qv, {4{rows[i].v}}); end
            checks++;
            if (ur !== {4{rows[i].u}}) begin errors++; $display("FAIL back_to_back[%0d] UNDERRUN got %b want %b", i, ur, {4{rows[i].u}}); end
        end
    endtask

    task automatic test_ce_freeze();
        row_t rows[$];
        rows.push_back(mk(1,0,0,1,8'hE4, 1, 8'h20, 0,0));
        rows.push_back(mk(1,0,0,0,8'h00, 0, 8'h0C, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'h59, 1,0));
        rows.push_back(mk(0,0,0,0,8'h00, 0, 8'h59, 1,0));
        rows.push_back(mk(0,0,0,0,8'h00, 0, 8'h59, 1,0));
        rows.push_back(mk(0,0,0,0,8'h00, 0, 8'h59, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hA6, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hF3, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hE0, 0,1));
        rows.push_back(mk(0,0,0,0,8'h00, 0, 8'hE0, 0,1));
        rows.push_back(mk(0,0,0,0,8'h00, 0, 8'hE0, 0,1));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hE0, 0,0));
        foreach (rows[i]) begin
            CE = rows[i].ce; R = rows[i].r; S = rows[i].s; D_VALID = rows[i].dv; D = rows[i].d;
            #1;
            checks++;
            if (rdy !== {4{rows[i].rdy}}) begin errors++; $display("FAIL ce_freeze[%0d] D_READY got %b want %b", i, rdy, {4{rows[i].rdy}}); end
            @(posedge C); #1;
            checks++;
            if (q4 !== rows[i].q) begin errors++; $display("FAIL ce_freeze[%0d] Q got %h want %h", i, q4, rows[i].q); end
            checks++;
            if (qv !== {4{rows[i].v}}) begin errors++; $display("FAIL ce_freeze[%0d] Q_VALID got %b want %b", i, qv, {4{rows[i].v}}); end
            checks++;
            if (ur !== {4{rows[i].u}}) begin errors++; $display("FAIL ce_freeze[%0d] UNDERRUN got %b want %b", i, ur, {4{rows[i].u}}); end
        end
    endtask

    task automatic test_reset_set();
        row_t rows[$];
        rows.push_back(mk(1,0,0,1,8'hE4, 1, 8'hE0, 0,0));
        rows.push_back(mk(1,0,0,0,8'h00, 0, 8'h0C, 1,0));
        rows.push_back(mk(1,0,0,1,8'h1B, 1, 8'h59, 1,0));
        rows.push_back(mk(1,1,1,0,8'h00, 0, 8'h00, 0,0));
        rows.push_back(mk(1,0,0,1,8'h4E, 1, 8'h20, 0,0));
        rows.push_back(mk(1,0,0,0,8'h00, 0, 8'hA6, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hF3, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'h0C, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'h59, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'h60, 0,1));
        rows.push_back(mk(1,0,0,1,8'hE4, 1, 8'h60, 0,0));
        rows.push_back(mk(1,0,0,0,8'h00, 0, 8'h0C, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'h59, 1,0));
        rows.push_back(mk(1,0,1,0,8'h00, 0, 8'hFF, 0,0));
        rows.push_back(mk(1,0,1,0,8'h00, 0, 8'hFF, 0,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hA6, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hF3, 1,0));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hE0, 0,1));
        rows.push_back(mk(1,0,0,0,8'h00, 1, 8'hE0, 0,0));
        foreach (rows[i]) begin
            CE = rows[i].ce; R = rows[i].r; S = rows[i].s; D_VALID = rows[i].dv; D = rows[i].d;
            #1;
            checks++;
            if (rdy !== {4{rows[i].rdy}}) begin errors++; $display("FAIL reset_set[%0d] D_READY got %b want %b", i, rdy, {4{rows[i].rdy}}); end
            @(posedge C); #1;
            checks++;
            if (q4 !== rows[i].q) begin errors++; $display("FAIL reset_set[%0d] Q got %h want %h", i, q4, rows[i].q); end
            checks++;
            if (qv !== {4{rows[i].v}}) begin errors++; $display("FAIL reset_set[%0d] Q_VALID got %b want %b", i, qv, {4{rows[i].v}}); end
            checks++;
            if (ur !== {4{rows[i].u}}) begin errors++; $display("FAIL reset_set[%0d] UNDERRUN got %b want %b", i, ur, {4{rows[i].u}}); end
        end
    endtask

    task automatic test_clr_n();
        row_t pre[$];
        row_t post[$];
        pre.push_back(mk(1,0,0,1,8'hE4, 1, 8'hE0, 0,0));
        pre.push_back(mk(1,0,0,0,8'h00, 0, 8'h0C, 1,0));
        pre.push_back(mk(1,0,0,1,8'h1B, 1, 8'h59, 1,0));
        post.push_back(mk(1,0,0,1,8'h4E, 1, 8'h60, 0,0));
        post.push_back(mk(1,0,0,0,8'h00, 0, 8'hA6, 1,0));
        post.push_back(mk(1,0,0,0,8'h00, 1, 8'hF3, 1,0));
        post.push_back(mk(1,0,0,0,8'h00, 1, 8'h0C, 1,0));
        post.push_back(mk(1,0,0,0,8'h00, 1, 8'h59, 1,0));
        post.push_back(mk(1,0,0,0,8'h00, 1, 8'h60, 0,1));
        foreach (pre[i]) begin
            CE = pre[i].ce; R = pre[i].r; S = pre[i].s; D_VALID = pre[i].dv; D = pre[i].d;
            #1;
            checks++;
            if (rdy !== {4{pre[i].rdy}}) begin errors++; $display("FAIL clr_n_pre[%0d] D_READY got %b want %b", i, rdy, {4{pre[i].rdy}}); end
            @(posedge C); #1;
            checks++;
            if (q4 !== pre[i].q) begin errors++; $display("FAIL clr_n_pre[%0d] Q got %h want %h", i, q4, pre[i].q); end
            checks++;
            if (qv !== {4{pre[i].v}}) begin errors++; $display("FAIL clr_n_pre[%0d] Q_VALID got %b want %b", i, qv, {4{pre[i].v}}); end
            checks++;
            if (ur !== {4{pre[i].u}}) begin errors++; $display("FAIL clr_n_pre[%0d] UNDERRUN got %b want %b", i, ur, {4{pre[i].u}}); end
        end
        // Pulse CLR_N between clock edges; outputs must react without an edge.
        #2 CLR_N = 1'b0;
        #1;
        checks++;
        if (q4 !== 8'h60) begin errors++; $display("FAIL clr_n_async Q got %h want %h", q4, 8'h60); end
        checks++;
        if (qv !== 4'h0) begin errors++; $display("FAIL clr_n_async Q_VALID got %b want %b", qv, 4'h0); end
        checks++;
        if (ur !== 4'h0) begin errors++; $display("FAIL clr_n_async UNDERRUN got %b want %b", ur, 4'h0); end
        CLR_N = 1'b1;
        #1;
        checks++;
        if (rdy !== 4'hF) begin errors++; $display("FAIL clr_n_release D_READY got %b want %b", rdy, 4'hF); end
        foreach (post[i]) begin
            CE = post[i].ce; R = post[i].r; S = post[i].s; D_VALID = post[i].dv; D = post[i].d;
            #1;
            checks++;
            if (rdy !== {4{post[i].rdy}}) begin errors++; $display("FAIL clr_n_post[%0d] D_READY got %b want %b", i, rdy, {4{post[i].rdy}}); end
            @(posedge C); #1;
            checks++;
            if (q4 !== post[i].q) begin errors++; $display("FAIL clr_n_post[%0d] Q got %h want %h", i, q4, post[i].q); end
            checks++;
            if (qv !== {4{post[i].v}}) begin errors++; $display("FAIL clr_n_post[%0d] Q_VALID got %b want %b", i, qv, {4{post[i].v}}); end
            checks++;
            if (ur !== {4{post[i].u}}) begin errors++; $display("FAIL clr_n_post[%0d] UNDERRUN got %b want %b", i, ur, {4{post[i].u}}); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_ce_freeze();
        test_reset_set();
        test_clr_n();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_gearbox_ser.md
Name: ddr_gearbox_ser

Overview:
- Parametrised N:1 output serializer; the next-generation successor to our 2:1 DDR output mux flops.
- Accepts a RATIO-slice parallel word of W-bit slices through a valid/ready handshake and emits one slice per clock on a registered output.
- Double-buffered (holding register plus shift register), so back-to-back words stream without bubbles.
- Keeps the familiar synchronous R/S/CE priority of our DDR flops.
- Sits between fabric data paths and IO pad flops/pins.

Parameters:
- W, 1, slice width in bits (1..16).
- RATIO, 2, slices per word (2..16; 1 not supported).
- MSB_FIRST, 0, 0 = slice 0 is D[W-1:0]; 1 = slice 0 is D[W*RATIO-1:W*(RATIO-1)].
- INIT, 0, W-bit value of Q after CLR_N and when idle with IDLE_MODE=0.
- IDLE_MODE, 0, 0 = Q drives INIT when no data; 1 = Q holds the last emitted slice.

Ports:
- C  in  1  clock, all state on posedge.
- CLR_N  in  1  asynchronous active-low reset.
- CE  in  1  clock enable; 0 freezes all state.
- R  in  1  synchronous reset, highest synchronous priority.
- S  in  1  synchronous set of Q; below R.
- D  in  W*RATIO  parallel word.
- D_VALID  in  1  word present on D.
- D_READY  out  1  block accepts D this cycle.
- Q  out  W  serial slice, registered.
- Q_VALID  out  1  Q carries a data slice.
- UNDERRUN  out  1  one-cycle pulse when the stream breaks.

Behaviour:
- State:
  - hold register and hold_full flag.
  - shift register sr, slice index idx, remaining-slice count rem (0..RATIO-1).
  - output registers Q, Q_VALID, UNDERRUN.
- CLR_N low (async, immediate): hold_full=0, rem=0, idx=0, Q=INIT, Q_VALID=0, UNDERRUN=0.
- D_READY = !hold_full & CE & !R & !S (combinational, no dependence on D_VALID).
- Accept = D_VALID & D_READY; on that edge hold<=D and hold_full<=1.
- Edge priority, evaluated in order:
  1. CE=0: nothing changes; UNDERRUN holds its value.
  2. R=1: hold_full=0, rem=0, Q=0, Q_VALID=0, UNDERRUN=0; any pending word is discarded.
  3. S=1: Q=all ones, Q_VALID=0, UNDERRUN=0; hold/sr/rem frozen; no accept.
  4. Normal operation, first matching case:
     - rem!=0: Q<=slice(sr,idx), idx++, rem--, Q_VALID<=1.
     - rem==0 and hold_full: Q<=slice0(hold), sr<=hold, idx<=1, rem<=RATIO-1, hold_full<=0 (same edge may also accept a new word only if D_READY was already 1, i.e. never; hold refills next cycle), Q_VALID<=1.
     - otherwise: Q<=INIT (IDLE_MODE=0) or unchanged (IDLE_MODE=1), Q_VALID<=0.
  5. UNDERRUN<=1 for exactly one cycle when Q_VALID was 1 and this edge takes the idle case; else 0.
- Latency: word accepted at edge t with the pipeline empty → slice0 on Q after edge t+1, last slice after edge t+RATIO.
- Throughput: one slice per CE cycle while D_VALID is held high; hold refills during the RATIO-1 shift cycles, so no gaps for RATIO>=2.
- Slice order: slice k = D[W*k+W-1:W*k] when MSB_FIRST=0, mirrored at slice granularity when MSB_FIRST=1; bit order within a slice is unchanged.
- Reset mid-word: R or CLR_N discards the partial word and the hold word; the first word accepted afterwards starts at slice 0.

Test Plan:
- W=2, RATIO=4, MSB_FIRST=0: reset, then D=8'hE4 valid for 1 cycle → Q=0,1,2,3 on 4 consecutive cycles, Q_VALID=1 throughout, then Q=INIT, Q_VALID=0, UNDERRUN=1 for one cycle.
- Same config, MSB_FIRST=1, D=8'hE4 → Q=3,2,1,0.
- Words 8'hE4 then 8'h1B presented back-to-back, D_VALID held high → 8 contiguous slices 0,1,2,3,3,2,1,0; no Q_VALID gap; D_READY low while hold is full.
- CE=0 for 3 cycles mid-word after slice 1 → Q stays 1, UNDERRUN unchanged; output resumes at slice 2.
- R and S asserted together mid-word → Q=0, Q_VALID=0; after release, new word 8'h4E → Q=2,3,0,1. S alone → Q=3, D_READY=0, resumes the frozen word afterwards.
- CLR_N pulsed low between edges mid-word with INIT=2'b10 → Q=2 immediately, Q_VALID=0, D_READY=1 on first cycle after release. IDLE_MODE=1 run: after the last slice 3, Q stays 3 while idle.
